pll_lock_supervisor: RTL and testbench

//  Drives the PLL reset input and consumes its lock output; it sits on the other side of the PLL's rst/locked interface.

---
 rtl/pll_lock_supervisor_pkg.sv | 22 ++
 rtl/pll_lock_supervisor_bit_sync.sv | 25 ++
 rtl/pll_lock_supervisor.sv | 140 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_supervisor_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encoding and
// a small helper used to size the common state timer.
package pll_sup_defs;

   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUNNING   = 3'd3,
      FAULT     = 3'd4
   } state_t;

   // Largest of three cycle counts; the timer must hold the longest interval.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level. Resets to 0 so a
// lock indication can never be seen during or straight after reset.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor on clk_74a. Pulses the PLL reset, waits for lock,
// requires lock to stay stable before releasing the video core, retries on
// timeout or loss of lock, and latches a fault after repeated failures.
module pll_lock_supervisor
   import pll_sup_defs::*;
#(
   parameter int LOCK_SYNC_STAGES    = 2,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 74250,
   parameter int LOCK_TIMEOUT_CYCLES = 742500,
   parameter int MAX_RETRIES         = 3
) (
   input  logic       clk_74a,
   input  logic       reset_n,
   input  logic       pll_locked,
   input  logic       clear_fault,
   output logic       pll_rst,
   output logic       core_reset_n,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_count,
   output logic [7:0] lock_loss_count
);

   localparam int MAX_CYC = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
   localparam int TW      = $clog2(MAX_CYC) + 1;

   localparam logic [TW-1:0] RST_LAST     = TW'(PLL_RST_CYCLES - 1);
   localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
   localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

   logic          lk;
   state_t        state, state_d;
   logic [TW-1:0] timer, timer_d;
   logic [3:0]    retry_d;
   logic [7:0]    loss_d;
   logic          pll_rst_d, core_reset_n_d, ready_d, fault_d;

   bit_sync #(
      .STAGES (LOCK_SYNC_STAGES)
   ) u_lock_sync (
      .clk   (clk_74a),
      .rst_n (reset_n),
      .d     (pll_locked),
      .q     (lk)
   );

   // Next-state, timer, counter and output decode.
   always_comb begin
      state_d = state;
      retry_d = retry_count;
      loss_d  = lock_loss_count;

      case (state)
         RESET_PLL: begin
            if (timer == RST_LAST) begin
               state_d = WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            // A lock seen in the timeout cycle still counts as a lock.
            if (lk) begin
               state_d = STABILIZE;
            end else if (timer == TIMEOUT_LAST) begin
               retry_d = retry_count + 4'd1;
               state_d = (retry_d == RETRY_LIMIT) ? FAULT : RESET_PLL;
            end
         end
         STABILIZE: begin
            // A drop on the completion cycle takes priority over release.
            if (!lk) begin
               state_d = WAIT_LOCK;
            end else if (timer == STABLE_LAST) begin
               state_d = RUNNING;
               retry_d = 4'd0;
            end
         end
         RUNNING: begin
            if (!lk) begin
               state_d = RESET_PLL;
               if (lock_loss_count != 8'hFF) begin
                  loss_d = lock_loss_count + 8'd1;
               end
            end
         end
         FAULT: begin
            if (clear_fault) begin
               state_d = RESET_PLL;
               retry_d = 4'd0;
            end
         end
         default: begin
            state_d = RESET_PLL;
         end
      endcase

      // The timer only runs in the timed states, each of which always leaves
      // at its terminal count, so it can never wrap.
      if (state_d != state) begin
         timer_d = '0;
      end else if ((state == RESET_PLL) || (state == WAIT_LOCK) || (state == STABILIZE)) begin
         timer_d = timer + TIMER_ONE;
      end else begin
         timer_d = timer;
      end

      // Outputs are decoded from the next state so they change on the same
      // edge as the transition that causes them.
      pll_rst_d      = (state_d == RESET_PLL) || (state_d == FAULT);
      core_reset_n_d = (state_d == RUNNING);
      ready_d        = (state_d == RUNNING);
      fault_d        = (state_d == FAULT);
   end

   // State, timer, counters and registered outputs.
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         state           <= RESET_PLL;
         timer           <= '0;
         retry_count     <= 4'd0;
         lock_loss_count <= 8'd0;
         pll_rst         <= 1'b1;
         core_reset_n    <= 1'b0;
         ready           <= 1'b0;
         fault           <= 1'b0;
      end else begin
         state           <= state_d;
         timer           <= timer_d;
         retry_count     <= retry_d;
         lock_loss_count <= loss_d;
         pll_rst         <= pll_rst_d;
         core_reset_n    <= core_reset_n_d;
         ready           <= ready_d;
         fault           <= fault_d;
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor with small cycle parameters.
module tb_pll_lock_supervisor;

   localparam int SYNC   = 2;
   localparam int RSTC   = 4;
   localparam int STABLE = 8;
   localparam int TMO    = 32;
   localparam int MAXR   = 2;
   localparam int LAT    = SYNC + STABLE + 1;

   // Reference model phases: PLL held in reset, acquiring lock, running, fault.
   localparam int PH_HOLD = 0;
   localparam int PH_ACQ  = 1;
   localparam int PH_RUN  = 2;
   localparam int PH_FLT  = 3;

   logic       clk_74a = 1'b0;
   logic       reset_n = 1'b1;
   logic       pll_locked = 1'b0;
   logic       clear_fault = 1'b0;
   logic       pll_rst, core_reset_n, ready, fault;
   logic [3:0] retry_count;
   logic [7:0] lock_loss_count;
   logic [15:0] obs;

   int vectors = 0;
   int miscompares = 0;

   int m_phase, m_cnt, m_high, m_low, m_tries, m_losses;
   logic [SYNC-1:0] m_sh;

   always #5 clk_74a = ~clk_74a;

   pll_lock_supervisor #(
      .LOCK_SYNC_STAGES    (SYNC),
      .PLL_RST_CYCLES      (RSTC),
      .LOCK_STABLE_CYCLES  (STABLE),
      .LOCK_TIMEOUT_CYCLES (TMO),
      .MAX_RETRIES         (MAXR)
   ) dut (
      .clk_74a         (clk_74a),
      .reset_n         (reset_n),
      .pll_locked      (pll_locked),
      .clear_fault     (clear_fault),
      .pll_rst         (pll_rst),
      .core_reset_n    (core_reset_n),
      .ready           (ready),
      .fault           (fault),
      .retry_count     (retry_count),
      .lock_loss_count (lock_loss_count)
   );

   assign obs = {pll_rst, core_reset_n, ready, fault, retry_count, lock_loss_count};

   function automatic logic [15:0] expected();
      logic [3:0] t;
      logic [7:0] l;
      t = 4'(m_tries);
      l = 8'(m_losses);
      return {(m_phase == PH_HOLD) || (m_phase == PH_FLT), m_phase == PH_RUN,
              m_phase == PH_RUN, m_phase == PH_FLT, t, l};
   endfunction

   task automatic model_reset();
      m_phase  = PH_HOLD;
      m_cnt    = 0;
      m_high   = 0;
      m_low    = 0;
      m_tries  = 0;
      m_losses = 0;
      m_sh     = '0;
   endtask

   // One clock edge of the reference behaviour. Lock acquisition is tracked
   // as the length of the current run of high/low synchronized samples.
   task automatic model_step();
      logic lk;
      lk   = m_sh[SYNC-1];
      m_sh = {m_sh[SYNC-2:0], pll_locked};
      case (m_phase)
         PH_HOLD: begin
            m_cnt++;
            if (m_cnt == RSTC) begin
               m_phase = PH_ACQ;
               m_high  = 0;
               m_low   = 0;
            end
         end
         PH_ACQ: begin
            if (lk) begin
               m_high++;
               m_low = 0;
               if (m_high == STABLE + 1) begin
                  m_phase = PH_RUN;
                  m_tries = 0;
               end
            end else if (m_high > 0) begin
               m_high = 0;
               m_low  = 0;
            end else begin
               m_low++;
               if (m_low == TMO) begin
                  m_tries++;
                  m_cnt   = 0;
                  m_phase = (m_tries == MAXR) ? PH_FLT : PH_HOLD;
               end
            end
         end
         PH_RUN: begin
            if (!lk) begin
               m_phase = PH_HOLD;
               m_cnt   = 0;
               if (m_losses < 255) m_losses++;
            end
         end
         default: begin
            if (clear_fault) begin
               m_phase = PH_HOLD;
               m_cnt   = 0;
               m_tries = 0;
            end
         end
      endcase
   endtask

   // Advance one clock; called at a falling edge, returns at the next one.
   task automatic tick();
      @(posedge clk_74a);
      model_step();
      @(negedge clk_74a);
   endtask

   // Called at a falling edge; leaves reset released at a falling edge.
   task automatic apply_reset();
      reset_n     = 1'b0;
      pll_locked  = 1'b0;
      clear_fault = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_74a);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      #3 reset_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (obs !== 16'h8000) begin
         miscompares++;
         $display("FAIL reset_async: got %h want %h", obs, 16'h8000);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_74a);
         vectors++;
         if (obs !== 16'h8000) begin
            miscompares++;
            $display("FAIL reset_hold %0d: got %h want %h", i, obs, 16'h8000);
         end
      end
   endtask

   task automatic test_lock_latency();
      int seen;
      reset_n = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         vectors++;
         if ((obs !== expected()) || (pll_rst !== (i < RSTC))) begin
            miscompares++;
            $display("FAIL s1_prelock %0d: got %h want %h (pll_rst want %0d)", i, obs, expected(), i < RSTC);
         end
      end
      pll_locked = 1'b1;
      seen = 0;
      for (int k = 1; k <= 60 && seen == 0; k++) begin
         tick();
         vectors++;
         if (obs !== expected()) begin
            miscompares++;
            $display("FAIL s1_model %0d: got %h want %h", k, obs, expected());
         end
         if (ready === 1'b1) seen = k;
      end
      vectors++;
      if ((seen != LAT) || (core_reset_n !== 1'b1)) begin
         miscompares++;
         $display("FAIL s1_latency: got %0d edges core_reset_n=%b, want %0d edges core_reset_n=1", seen, core_reset_n, LAT);
      end
   endtask

   task automatic test_glitch();
      int seen;
      apply_reset();
      for (int i = 0; i < 6; i++) tick();
      pll_locked = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      seen = 0;
      for (int k = 1; k <= 60 && seen == 0; k++) begin
         tick();
         vectors++;
         if (obs !== expected()) begin
            miscompares++;
            $display("FAIL s2_model %0d: got %h want %h", k, obs, expected());
         end
         if (ready === 1'b1) seen = k;
      end
      vectors++;
      if ((seen != LAT) || (retry_count !== 4'd0)) begin
         miscompares++;
         $display("FAIL s2_glitch: got %0d edges retry=%0d, want %0d edges retry=0", seen, retry_count, LAT);
      end
   endtask

   task automatic test_timeout_fault();
      apply_reset();
      for (int i = 1; i <= RSTC + TMO; i++) begin
         tick();
         vectors++;
         if (obs !== expected()) begin
            miscompares++;
            $display("FAIL s3_model_a %0d: got %h want %h", i, obs, expected());
         end
      end
      vectors++;
      if ((retry_count !== 4'd1) || (pll_rst !== 1'b1) || (fault !== 1'b0)) begin
         miscompares++;
         $display("FAIL s3_first_timeout: got retry=%0d pll_rst=%b fault=%b, want 1 1 0", retry_count, pll_rst, fault);
      end
      for (int i = 1; i <= RSTC + TMO; i++) begin
         tick();
         vectors++;
         if (obs !== expected()) begin
            miscompares++;
            $display("FAIL s3_model_b %0d: got %h want %h", i, obs, expected());
         end
      end
      vectors++;
      if ((fault !== 1'b1) || (pll_rst !== 1'b1) || (retry_count !== 4'd2) || (ready !== 1'b0)) begin
         miscompares++;
         $display("FAIL s3_fault: got fault=%b pll_rst=%b retry=%0d ready=%b, want 1 1 2 0", fault, pll_rst, retry_count, ready);
      end
      pll_locked = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      vectors++;
      if ((fault !== 1'b1) || (obs !== expected())) begin
         miscompares++;
         $display("FAIL s3_fault_held: got %h want %h", obs, expected());
      end
      pll_locked = 1'b0;
   endtask

   task automatic test_clear_fault();
      int seen;
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      vectors++;
      if ((fault !== 1'b0) || (retry_count !== 4'd0) || (pll_rst !== 1'b1)) begin
         miscompares++;
         $display("FAIL s4_clear: got fault=%b retry=%0d pll_rst=%b, want 0 0 1", fault, retry_count, pll_rst);
      end
      for (int i = 0; i < 4; i++) tick();
      pll_locked = 1'b1;
      seen = 0;
      for (int k = 1; k <= 60 && seen == 0; k++) begin
         tick();
         vectors++;
         if (obs !== expected()) begin
            miscompares++;
            $display("FAIL s4_model %0d: got %h want %h", k, obs, expected());
         end
         if (ready === 1'b1) seen = k;
      end
      vectors++;
      if (seen != LAT) begin
         miscompares++;
         $display("FAIL s4_latency: got %0d edges want %0d", seen, LAT);
      end
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      tick();
      vectors++;
      if ((ready !== 1'b1) || (pll_rst !== 1'b0) || (fault !== 1'b0)) begin
         miscompares++;
         $display("FAIL s4_clear_ignored: got ready=%b pll_rst=%b fault=%b, want 1 0 0", ready, pll_rst, fault);
      end
   endtask

   task automatic test_lock_loss();
      int seen;
      for (int n = 1; n <= 300; n++) begin
         pll_locked = 1'b0;
         seen = 0;
         for (int k = 1; k <= 20 && seen == 0; k++) begin
            tick();
            vectors++;
            if (obs !== expected()) begin
               miscompares++;
               $display("FAIL s5_drop_model %0d/%0d: got %h want %h", n, k, obs, expected());
            end
            if (core_reset_n === 1'b0) seen = k;
         end
         vectors++;
         if ((seen != SYNC + 1) || (ready !== 1'b0) || (pll_rst !== 1'b1) ||
             (lock_loss_count !== 8'((n > 255) ? 255 : n))) begin
            miscompares++;
            $display("FAIL s5_drop %0d: got %0d edges ready=%b pll_rst=%b count=%0d, want %0d 0 1 %0d",
                     n, seen, ready, pll_rst, lock_loss_count, SYNC + 1, (n > 255) ? 255 : n);
         end
         pll_locked = 1'b1;
         seen = 0;
         for (int k = 1; k <= 60 && seen == 0; k++) begin
            tick();
            vectors++;
            if (obs !== expected()) begin
               miscompares++;
               $display("FAIL s5_relock_model %0d/%0d: got %h want %h", n, k, obs, expected());
            end
            if (ready === 1'b1) seen = k;
         end
         if (seen == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL s5_relock_timeout %0d: got ready=%b want 1", n, ready);
         end
      end
      vectors++;
      if (lock_loss_count !== 8'd255) begin
         miscompares++;
         $display("FAIL s5_saturate: got %0d want 255", lock_loss_count);
      end
   endtask

   task automatic test_async_reset();
      int seen;
      apply_reset();
      for (int i = 0; i < 6; i++) tick();
      pll_locked = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (obs !== 16'h8000) begin
         miscompares++;
         $display("FAIL s6_stabilize_reset: got %h want %h", obs, 16'h8000);
      end
      @(negedge clk_74a);
      reset_n = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         seen = 0;
         for (int k = 1; k <= 60 && seen == 0; k++) begin
            tick();
            if (ready === 1'b1) seen = k;
         end
         if (pass == 0) begin
            pll_locked = 1'b0;
            for (int k = 0; k < 4; k++) tick();
            pll_locked = 1'b1;
         end
      end
      vectors++;
      if ((obs !== expected()) || (lock_loss_count !== 8'd1)) begin
         miscompares++;
         $display("FAIL s6_running: got %h want %h", obs, expected());
      end
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (obs !== 16'h8000) begin
         miscompares++;
         $display("FAIL s6_running_reset: got %h want %h", obs, 16'h8000);
      end
      @(negedge clk_74a);
      reset_n = 1'b1;
      pll_locked = 1'b0;
   endtask

   task automatic test_random();
      int cyc;
      int len;
      cyc = 0;
      apply_reset();
      while (cyc < 4000) begin
         if ($urandom_range(0, 29) == 0) apply_reset();
         pll_locked = 1'($urandom_range(0, 1));
         len = pll_locked ? $urandom_range(1, 30) : $urandom_range(1, 50);
         for (int i = 0; i < len; i++) begin
            clear_fault = ($urandom_range(0, 19) == 0);
            tick();
            cyc++;
            vectors++;
            if (obs !== expected()) begin
               miscompares++;
               $display("FAIL random %0d: got %h want %h", cyc, obs, expected());
            end
         end
      end
      clear_fault = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_lock_latency();
      test_glitch();
      test_timeout_fault();
      test_clear_fault();
      test_lock_loss();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
